// File: rtl/phase_addr_pkg.sv
// Shared types and elaboration-time helpers for the phase address generator.
// Parameter-dependent widths are derived here so every file uses the same values.
package phase_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input longint value);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Accumulator modulus: DIV counts per address step times 2^ADDR_W steps.
  function automatic longint calc_mod(input int div, input int addr_w);
    return longint'(div) << addr_w;
  endfunction

  function automatic int calc_acc_w(input int div, input int addr_w);
    return clog2(calc_mod(div, addr_w));
  endfunction

endpackage

// File: rtl/phase_addr_gen_mc_serial_udiv.sv
// Restoring divider by a constant: one quotient bit per cycle, MSB first.
// o_quot is valid in the o_done cycle and includes the final bit.
module serial_udiv #(
  parameter int ACC_W  = 25,
  parameter int ADDR_W = 11,
  parameter int DIV    = 15625
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ACC_W-1:0]  i_dividend,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_quot
);

  // Dividend is guaranteed below DIV * 2^ADDR_W, so ADDR_W steps suffice.
  localparam logic [ACC_W-1:0]  DSR_INIT  = ACC_W'(longint'(DIV) << (ADDR_W - 1));
  localparam logic [ADDR_W-1:0] MASK_INIT = ADDR_W'(1) << (ADDR_W - 1);

  logic [ACC_W-1:0]  r_rem;
  logic [ACC_W-1:0]  r_dsr;
  logic [ADDR_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_quot;
  logic              r_run;
  logic              w_ge;

  assign w_ge   = (r_rem >= r_dsr);
  assign o_quot = w_ge ? (r_quot | r_mask) : r_quot;
  assign o_done = r_run & r_mask[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_dsr  <= '0;
      r_mask <= '0;
      r_quot <= '0;
      r_run  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= i_dividend;
      r_dsr  <= DSR_INIT;
      r_mask <= MASK_INIT;
      r_quot <= '0;
      r_run  <= 1'b1;
    end else if (r_run) begin
      if (w_ge) r_rem <= r_rem - r_dsr;
      r_quot <= o_quot;
      r_dsr  <= r_dsr >> 1;
      r_mask <= r_mask >> 1;
      if (r_mask[0]) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_addr_gen_mc.sv
// Multi-channel modulo phase accumulator feeding ROM addresses, one shared
// serial divider; all channel addresses commit together on addr_valid.
module phase_addr_gen_mc
  import phase_addr_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 11,
  parameter int FREQ_W     = 19,
  parameter int FREQ_SCALE = 32,
  parameter int DIV        = 15625
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_clk,
  input  logic                     sync_clr,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH*FREQ_W-1:0] f_set,
  input  logic [NUM_CH*ADDR_W-1:0] phase_off,
  output logic [NUM_CH*ADDR_W-1:0] addr,
  output logic                     addr_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam longint MOD   = calc_mod(DIV, ADDR_W);
  localparam int     ACC_W = calc_acc_w(DIV, ADDR_W);
  localparam int     CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int     INC_W = FREQ_W + 32;

  localparam logic [INC_W-1:0]  MOD_I   = INC_W'(MOD);
  localparam logic [ACC_W:0]    MOD_S   = (ACC_W + 1)'(MOD);
  localparam logic [ACC_W-1:0]  MOD_T   = ACC_W'(MOD);
  localparam logic [ACC_W-1:0]  MOD_M1  = ACC_W'(MOD - 1);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic              r_en_s;
  logic [ADDR_W-1:0] r_off_s;
  logic              r_valid;
  logic              r_busy;
  logic              r_ovr;
  logic              r_s0, r_s1, r_s2;
  logic [ACC_W-1:0]  r_acc    [NUM_CH];
  logic [ADDR_W-1:0] r_shadow [NUM_CH];
  logic [ADDR_W-1:0] r_addr   [NUM_CH];

  logic [FREQ_W-1:0] w_f_arr   [NUM_CH];
  logic [ADDR_W-1:0] w_off_arr [NUM_CH];
  logic              w_tick;
  logic [INC_W-1:0]  w_inc_full;
  logic [ACC_W-1:0]  w_inc;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_div_start;
  logic [ACC_W-1:0]  w_div_in;
  logic              w_div_done;
  logic [ADDR_W-1:0] w_quot;
  logic [ADDR_W-1:0] w_addr_calc;

  // addr_valid is a one-cycle strobe with no backpressure; addr holds until the next strobe.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_f_arr[k]                   = f_set[k*FREQ_W +: FREQ_W];
    assign w_off_arr[k]                 = phase_off[k*ADDR_W +: ADDR_W];
    assign addr[k*ADDR_W +: ADDR_W]     = r_addr[k];
  end

  assign addr_valid = r_valid;
  assign busy       = r_busy;
  assign overrun    = r_ovr;
  assign w_tick     = r_s1 & ~r_s2;

  assign w_inc_full  = INC_W'(w_f_arr[r_ch]) * INC_W'(FREQ_SCALE);
  assign w_inc       = (w_inc_full >= MOD_I) ? MOD_M1 : w_inc_full[ACC_W-1:0];
  assign w_sum       = {1'b0, r_acc[r_ch]} + {1'b0, w_inc};
  // Low-bit subtraction is exact because the wrapped result is below MOD.
  assign w_acc_nxt   = (w_sum >= MOD_S) ? (w_sum[ACC_W-1:0] - MOD_T) : w_sum[ACC_W-1:0];
  assign w_div_start = (r_state == ST_ACC) && !sync_clr;
  assign w_div_in    = en[r_ch] ? w_acc_nxt : r_acc[r_ch];
  assign w_addr_calc = w_quot + r_off_s;

  serial_udiv #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W),
    .DIV    (DIV)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_div_in),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s0 <= s_clk;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_en_s  <= 1'b0;
      r_off_s <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k]    <= '0;
        r_shadow[k] <= '0;
        r_addr[k]   <= '0;
      end
    end else if (sync_clr) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k]    <= '0;
        r_shadow[k] <= '0;
        r_addr[k]   <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      r_ovr   <= w_tick && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_en_s  <= en[r_ch];
          r_off_s <= w_off_arr[r_ch];
          if (en[r_ch]) r_acc[r_ch] <= w_acc_nxt;
          r_state <= ST_DIV;
        end
        ST_DIV: begin
          if (w_div_done) begin
            if (r_en_s) r_shadow[r_ch] <= w_addr_calc;
            if (r_ch == LAST_CH) begin
              // Commit uses the shadow value being written this same cycle.
              for (int k = 0; k < NUM_CH; k++)
                r_addr[k] <= (CH_W'(k) == r_ch && r_en_s) ? w_addr_calc : r_shadow[k];
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= ST_ACC;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_addr_gen_mc.sv
// Directed bench for phase_addr_gen_mc: expected commits are queued as ticks
// are issued and a monitor compares them against each addr_valid strobe.
module tb_phase_addr_gen_mc;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 11;
  localparam int FREQ_W = 19;
  localparam int W      = NUM_CH * ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_clk;
  logic                     sync_clr;
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH*FREQ_W-1:0] f_set;
  logic [NUM_CH*ADDR_W-1:0] phase_off;
  logic [W-1:0]             addr;
  logic                     addr_valid;
  logic                     busy;
  logic                     overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_valid = 0;
  int n_ovr   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  phase_addr_gen_mc #(
    .NUM_CH     (NUM_CH),
    .ADDR_W     (ADDR_W),
    .FREQ_W     (FREQ_W),
    .FREQ_SCALE (32),
    .DIV        (15625)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_clk      (s_clk),
    .sync_clr   (sync_clr),
    .en         (en),
    .f_set      (f_set),
    .phase_off  (phase_off),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic logic [W-1:0] pk(input int a1, input int a0);
    logic [ADDR_W-1:0] x1, x0;
    x1 = a1[ADDR_W-1:0];
    x0 = a0[ADDR_W-1:0];
    return {x1, x0};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (overrun) n_ovr++;
    if (addr_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("sb_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr0", addr[ADDR_W-1:0], e[ADDR_W-1:0]);
        chk("sb_addr1", addr[W-1:ADDR_W], e[W-1:ADDR_W]);
      end
    end
  end

  // driver tasks
  task automatic set_ch(input int k, input int f, input int off);
    f_set[k*FREQ_W +: FREQ_W]     = f[FREQ_W-1:0];
    phase_off[k*ADDR_W +: ADDR_W] = off[ADDR_W-1:0];
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    s_clk = 1'b1;
    repeat (4) @(negedge clk);
    s_clk = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  task automatic tick_wait(input logic [W-1:0] e);
    int v0;
    exp_q.push_back(e);
    v0 = n_valid;
    pulse_tick();
    for (int i = 0; i < 60 && n_valid == v0; i++) @(posedge clk);
    chk("valid_seen", n_valid - v0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int v0, o0, lat;
    rst = 1'b0; s_clk = 1'b0; sync_clr = 1'b0;
    en = '0; f_set = '0; phase_off = '0;
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic advance: 32000 per tick, addr0 = floor(n*32000/15625)
    en = 2'b01;
    set_ch(0, 1000, 0);
    set_ch(1, 0, 0);
    for (int n = 1; n <= 500; n++)
      tick_wait(pk(0, (n * 32000 % 32000000) / 15625));
    chk("addr0_after_500", addr[ADDR_W-1:0], 1024);

    // asynchronous reset in the middle of a sequence
    pulse_tick();
    repeat (8) @(negedge clk);
    chk("busy_in_seq", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_addr", addr, 0);
    chk("midrst_valid", addr_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // first tick after reset: value and latency from the s_clk edge
    exp_q.push_back(pk(0, 2));
    s_clk = 1'b1;
    lat = 0;
    while (!addr_valid && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 4) s_clk = 1'b0;
    end
    s_clk = 1'b0;
    chk("tick_to_valid_latency", lat, 27);
    repeat (3) @(negedge clk);

    // wrap at MOD
    pulse_clr();
    chk("clr_addr", addr, 0);
    set_ch(0, 500000, 0);
    tick_wait(pk(0, 1024));
    tick_wait(pk(0, 0));
    tick_wait(pk(0, 1024));

    // enable and offset
    pulse_clr();
    en = 2'b10;
    set_ch(1, 0, 100);
    set_ch(0, 1000, 0);
    tick_wait(pk(100, 0));
    en = 2'b01;
    set_ch(1, 0, 0);
    set_ch(0, 1000, 2047);
    tick_wait(pk(100, 1));

    // two s_clk edges 10 cycles apart: one commit, one overrun
    o0 = n_ovr;
    v0 = n_valid;
    exp_q.push_back(pk(100, 3));
    @(negedge clk);
    s_clk = 1'b1;
    repeat (4) @(negedge clk);
    s_clk = 1'b0;
    repeat (6) @(negedge clk);
    s_clk = 1'b1;
    repeat (4) @(negedge clk);
    s_clk = 1'b0;
    repeat (60) @(posedge clk);
    chk("overrun_pulses", n_ovr - o0, 1);
    chk("overrun_valids", n_valid - v0, 1);
    repeat (3) @(negedge clk);

    // sync_clr in cycle 5 of a sequence
    v0 = n_valid;
    @(negedge clk);
    s_clk = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    s_clk = 1'b0;
    repeat (3) @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_addr_mid", addr, 0);
    repeat (40) @(posedge clk);
    chk("clr_no_valid", n_valid - v0, 0);
    repeat (2) @(negedge clk);
    set_ch(0, 1000, 0);
    set_ch(1, 0, 0);
    tick_wait(pk(0, 2));

    // both channels enabled
    en = 2'b11;
    set_ch(1, 250000, 5);
    tick_wait(pk(517, 4));

    chk("sb_drained", exp_q.size(), 0);
    chk("overrun_total", n_ovr, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/phase_addr_gen_mc.md
# phase_addr_gen_mc

Multi-channel, parametrised phase-accumulator address generator for the FIR/DDS coefficient and waveform ROMs. On each rising edge of the slow sample clock s_clk, detected in the clk domain, it advances one modulo-MOD phase accumulator per enabled channel. Each new accumulator value is divided serially by DIV to form an ADDR_W-bit ROM address, and an optional per-channel phase offset is added. All channel addresses then commit together with a one-cycle valid strobe. One instance sits between the front-panel frequency registers and the ROM address ports, and it serves every channel through a single time-shared divider.

## Interface
- NUM_CH, 2: number of channels (≥1).
- ADDR_W, 11: ROM address width.
- FREQ_W, 19: per-channel frequency word width.
- FREQ_SCALE, 32: increment = f_set × FREQ_SCALE.
- DIV, 15625: accumulator counts per address step.
- Derived: MOD = DIV × 2^ADDR_W (32,000,000 at defaults); ACC_W = clog2(MOD) (25 at defaults).

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- s_clk  in  1  sample clock, asynchronous to clk.
- sync_clr  in  1  synchronous clear of all accumulators and addresses.
- en  in  NUM_CH  per-channel advance enable.
- f_set  in  NUM_CH×FREQ_W  frequency words; channel k is at bits [k×FREQ_W +: FREQ_W].
- phase_off  in  NUM_CH×ADDR_W  per-channel address offsets.
- addr  out  NUM_CH×ADDR_W  committed addresses.
- addr_valid  out  1  one-cycle pulse when addr is updated.
- busy  out  1  high while a sequence is in progress (state ≠ IDLE).
- overrun  out  1  one-cycle pulse when a tick is dropped.

## Operation
- **s_clk sync:** 2-flop synchroniser, then an edge register. tick = s1 & ~s2.
- **Increment:** inc = f_set × FREQ_SCALE. If inc ≥ MOD, it saturates to MOD−1. This cannot occur at default parameters (max inc is 16,777,184).
- **Accumulate:** sum = acc + inc, computed at ACC_W+1 bits. acc ← (sum ≥ MOD) ? sum − MOD : sum. The invariant acc < MOD always holds.
- **Divide:** quotient q = acc / DIV, which is always < 2^ADDR_W. It uses restoring division producing one quotient bit per cycle, MSB first.
- **Address:** address = (q + phase_off) mod 2^ADDR_W. The address is derived from the post-update accumulator, with no one-tick lag.
- **FSM states:** IDLE, ACC, DIV, DONE.
  - IDLE: on tick, set ch ← 0 and go to ACC.
  - ACC (1 cycle):
    - Sample en[ch], f_set[ch] and phase_off[ch].
    - If en is high, update acc[ch]; if low, hold it.
    - Load the divider with the resulting acc[ch].
  - DIV (ADDR_W cycles):
    - On the last cycle, if en was high, write shadow[ch] ← address; otherwise shadow[ch] holds.
    - If ch = NUM_CH−1, go to DONE; else ch ← ch+1 and go to ACC.
  - DONE (1 cycle): addr ← shadow for all channels; addr_valid = 1; go to IDLE.
- **Dropped ticks:** a tick seen in any state other than IDLE is dropped and overrun pulses for 1 cycle.
- **sync_clr** has priority over everything:
  - Clears all acc, shadow and addr to 0.
  - FSM returns to IDLE with no addr_valid.
  - A tick in the same cycle is dropped, without an overrun pulse.
- **Reset** (async, any time including mid-sequence): acc, shadow and addr = 0; addr_valid, busy and overrun = 0; FSM = IDLE; synchroniser flops = 0.

## Timing
- Tick detection: 3 clk cycles after the s_clk rising edge (±1 for synchronisation).
- addr_valid asserts NUM_CH×(ADDR_W+1)+1 cycles after the tick cycle. At defaults that is 25 cycles.
- addr changes only in the addr_valid cycle. It is stable between commits.
- busy is high from the cycle after the tick through the DONE cycle inclusive.
- Minimum s_clk period is NUM_CH×(ADDR_W+1)+2 clk cycles. Faster ticks cause overrun.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Shared package** (`phase_addr_pkg`):
  - FSM state enum.
  - clog2 function.
  - MOD/ACC_W derivation functions.
- **Sub-module** `serial_udiv`: restoring divider with start/done, dividend ACC_W, divisor DIV constant, quotient ADDR_W, fixed ADDR_W-cycle latency.
- **Top level:** accumulator array, channel counter, FSM, shadow/commit registers and synchroniser.

## Test plan
1. **Reset:** assert rst mid-sequence (in DIV) → addr = 0, addr_valid/busy/overrun = 0 immediately. After release, the first tick produces valid output 25 cycles later.
2. **Basic advance:** ch0 f_set = 1000, en = 01.
   - After 1 tick: acc0 = 32,000, addr0 = 2, addr1 = 0.
   - After 500 ticks: addr0 = 1024.
3. **Wrap:** ch0 f_set = 500,000 (inc 16,000,000).
   - Tick 1: addr0 = 1024.
   - Tick 2: sum = MOD, so acc0 = 0 and addr0 = 0.
   - Tick 3: addr0 = 1024.
4. **Enable and offset:** en = 01, ch1 preloaded to addr1 = 100, ch0 f_set = 1000, phase_off0 = 2047 → after tick, addr0 = 1 (wrap mod 2048) and addr1 stays 100.
5. **Overrun:** two s_clk edges 10 clk cycles apart → exactly one overrun pulse and exactly one addr_valid, with values reflecting a single advance.
6. **sync_clr:** pulse sync_clr in cycle 5 of a sequence → no addr_valid, busy drops next cycle, addr = 0. The next tick from ch0 f_set = 1000 gives addr0 = 2.
